uart_instr_loader: RTL

Parametrised successor to the fixed 16-bit UART instruction-BRAM init path. It receives a framed program image over UART and assembles DATA_WIDTH-bit words from bytes sent LSB-first. It writes each word to an external instruction memory through a simple write port. The frame carries a length header and an XOR checksum, and the block reports done or error status to the CPU's boot/reset control. Single clock domain; the UART deserializer runs on i_clk.

---
 rtl/uart_instr_loader_pkg.sv | 18 +
 rtl/uart_instr_loader_rx.sv | 93 +++++++++
 rtl/uart_instr_loader.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/uart_instr_loader_pkg.sv
// Shared types for the UART instruction loader: FSM encodings and error codes.
package uart_instr_loader_pkg;

   typedef enum logic [2:0] {
      S_LEN_LO, S_LEN_HI, S_DATA, S_CSUM, S_DONE, S_ERR
   } ld_state_e;

   typedef enum logic [1:0] {
      RX_IDLE, RX_START, RX_DATA, RX_STOP
   } rx_state_e;

   localparam logic [2:0] ERR_NONE    = 3'd0;
   localparam logic [2:0] ERR_FRAME   = 3'd1;
   localparam logic [2:0] ERR_LEN     = 3'd2;
   localparam logic [2:0] ERR_CSUM    = 3'd3;
   localparam logic [2:0] ERR_TIMEOUT = 3'd4;

endpackage

// File: rtl/uart_instr_loader_rx.sv
// 8N1 UART byte receiver: synchronised input, mid-bit sampling, start-glitch rejection.
module uart_rx_byte
   import uart_instr_loader_pkg::*;
#(
   parameter int CLKS_PER_BIT = 868
) (
   input  logic       i_clk,
   input  logic       i_rst_n,
   input  logic       i_rx,
   input  logic       i_flush,
   output logic [7:0] o_byte,
   output logic       o_valid,
   output logic       o_frame_err
);
   localparam int CW = $clog2(CLKS_PER_BIT);

   rx_state_e      state_q, state_d;
   logic [2:0]     sync_q;
   logic [CW-1:0]  cnt_q, cnt_d;
   logic [2:0]     bit_q, bit_d;
   logic [7:0]     sh_q, sh_d;
   logic           valid_q, valid_d, ferr_q, ferr_d;
   logic           rx_s, fall, tick_half, tick_full;

   // sync_q[1] is the synchronised line; sync_q[2] is its previous value for edge detect
   assign rx_s      = sync_q[1];
   assign fall      = sync_q[2] & ~sync_q[1];
   assign tick_half = (cnt_q == CW'(CLKS_PER_BIT/2 - 1));
   assign tick_full = (cnt_q == CW'(CLKS_PER_BIT - 1));

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         sync_q  <= 3'b111;
         state_q <= RX_IDLE;
         cnt_q   <= '0;
         bit_q   <= '0;
         sh_q    <= '0;
         valid_q <= 1'b0;
         ferr_q  <= 1'b0;
      end else begin
         sync_q  <= {sync_q[1:0], i_rx};
         state_q <= state_d;
         cnt_q   <= cnt_d;
         bit_q   <= bit_d;
         sh_q    <= sh_d;
         valid_q <= valid_d;
         ferr_q  <= ferr_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q + 1'b1;
      bit_d   = bit_q;
      sh_d    = sh_q;
      valid_d = 1'b0;
      ferr_d  = ferr_q;
      case (state_q)
         RX_IDLE: begin
            cnt_d = '0;
            bit_d = '0;
            if (fall) state_d = RX_START;
         end
         RX_START: if (tick_half) begin
            cnt_d   = '0;
            state_d = rx_s ? RX_IDLE : RX_DATA;
         end
         RX_DATA: if (tick_full) begin
            cnt_d = '0;
            sh_d  = {rx_s, sh_q[7:1]};
            bit_d = bit_q + 1'b1;
            if (bit_q == 3'd7) state_d = RX_STOP;
         end
         RX_STOP: if (tick_full) begin
            cnt_d   = '0;
            valid_d = 1'b1;
            ferr_d  = ~rx_s;
            state_d = RX_IDLE;
         end
         default: state_d = RX_IDLE;
      endcase
      if (i_flush) begin
         state_d = RX_IDLE;
         cnt_d   = '0;
         valid_d = 1'b0;
      end
   end

   assign o_byte      = sh_q;
   assign o_valid     = valid_q;
   assign o_frame_err = ferr_q;

endmodule

// File: rtl/uart_instr_loader.sv
// Loads a length-prefixed, XOR-checksummed program image from UART into instruction memory.
module uart_instr_loader
   import uart_instr_loader_pkg::*;
#(
   parameter int CLKS_PER_BIT = 868,
   parameter int DATA_WIDTH   = 16,
   parameter int ADDR_WIDTH   = 8,
   parameter int TIMEOUT_CLKS = 16*868*10
) (
   input  logic                  i_clk,
   input  logic                  i_rst_n,
   input  logic                  i_rx,
   input  logic                  i_rearm,
   output logic                  o_mem_we,
   output logic [ADDR_WIDTH-1:0] o_mem_addr,
   output logic [DATA_WIDTH-1:0] o_mem_wdata,
   output logic                  o_busy,
   output logic                  o_load_done,
   output logic                  o_load_err,
   output logic [2:0]            o_err_code,
   output logic [ADDR_WIDTH:0]   o_words_loaded
);
   localparam int BPW = DATA_WIDTH/8;
   localparam int BIW = (BPW > 1) ? $clog2(BPW) : 1;
   localparam int TW  = $clog2(TIMEOUT_CLKS + 1);

   ld_state_e             state_q, state_d;
   logic [15:0]           len_q, len_d, len_n;
   logic [7:0]            csum_q, csum_d;
   logic [BIW-1:0]        bidx_q, bidx_d;
   logic [DATA_WIDTH-1:0] word_q, word_d, word_asm, wdata_q, wdata_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [ADDR_WIDTH:0]   cnt_q, cnt_d;
   logic [TW-1:0]         idle_q, idle_d;
   logic [2:0]            code_q, code_d;
   logic                  we_q, we_d;
   logic [7:0]            rx_byte;
   logic                  rx_valid, rx_ferr, acc, in_frame;

   uart_rx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
      .i_clk(i_clk), .i_rst_n(i_rst_n), .i_rx(i_rx), .i_flush(i_rearm),
      .o_byte(rx_byte), .o_valid(rx_valid), .o_frame_err(rx_ferr)
   );

   assign acc      = rx_valid & ~rx_ferr;
   assign in_frame = (state_q == S_LEN_HI) || (state_q == S_DATA) || (state_q == S_CSUM);
   assign len_n    = {rx_byte, len_q[7:0]};

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q <= S_LEN_LO;
         len_q   <= '0;
         csum_q  <= '0;
         bidx_q  <= '0;
         word_q  <= '0;
         wdata_q <= '0;
         addr_q  <= '0;
         cnt_q   <= '0;
         idle_q  <= '0;
         code_q  <= ERR_NONE;
         we_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         len_q   <= len_d;
         csum_q  <= csum_d;
         bidx_q  <= bidx_d;
         word_q  <= word_d;
         wdata_q <= wdata_d;
         addr_q  <= addr_d;
         cnt_q   <= cnt_d;
         idle_q  <= idle_d;
         code_q  <= code_d;
         we_q    <= we_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      len_d    = len_q;
      csum_d   = csum_q;
      bidx_d   = bidx_q;
      word_d   = word_q;
      wdata_d  = wdata_q;
      addr_d   = addr_q;
      cnt_d    = cnt_q;
      idle_d   = '0;
      code_d   = code_q;
      we_d     = 1'b0;
      word_asm = word_q;
      word_asm[{bidx_q, 3'b000} +: 8] = rx_byte;

      // address/count advance once the write strobe has been presented
      if (we_q) begin
         addr_d = addr_q + 1'b1;
         cnt_d  = cnt_q + 1'b1;
      end

      case (state_q)
         S_LEN_LO: if (acc) begin
            len_d[7:0] = rx_byte;
            csum_d     = csum_q ^ rx_byte;
            state_d    = S_LEN_HI;
         end
         S_LEN_HI: if (acc) begin
            len_d  = len_n;
            csum_d = csum_q ^ rx_byte;
            if (32'(len_n) > (32'd1 << ADDR_WIDTH)) begin
               state_d = S_ERR;
               code_d  = ERR_LEN;
            end else if (len_n == 16'd0) state_d = S_CSUM;
            else                         state_d = S_DATA;
         end
         S_DATA: if (acc) begin
            csum_d = csum_q ^ rx_byte;
            word_d = word_asm;
            if (bidx_q == BIW'(BPW - 1)) begin
               bidx_d  = '0;
               we_d    = 1'b1;
               wdata_d = word_asm;
               if ((17'(cnt_q) + 17'd1) == 17'(len_q)) state_d = S_CSUM;
            end else begin
               bidx_d = bidx_q + 1'b1;
            end
         end
         S_CSUM: if (acc) begin
            if (rx_byte == csum_q) state_d = S_DONE;
            else begin
               state_d = S_ERR;
               code_d  = ERR_CSUM;
            end
         end
         default: ;
      endcase

      if (in_frame) begin
         idle_d = rx_valid ? '0 : idle_q + 1'b1;
         if (!rx_valid && idle_q == TW'(TIMEOUT_CLKS - 1)) begin
            state_d = S_ERR;
            code_d  = ERR_TIMEOUT;
         end
      end

      if (rx_valid && rx_ferr && state_q != S_DONE && state_q != S_ERR) begin
         state_d = S_ERR;
         code_d  = ERR_FRAME;
         we_d    = 1'b0;
      end

      if (i_rearm) begin
         state_d = S_LEN_LO;
         len_d   = '0;
         csum_d  = '0;
         bidx_d  = '0;
         addr_d  = '0;
         cnt_d   = '0;
         idle_d  = '0;
         code_d  = ERR_NONE;
         we_d    = 1'b0;
      end
   end

   assign o_mem_we       = we_q & ~i_rearm;
   assign o_mem_addr     = addr_q;
   assign o_mem_wdata    = wdata_q;
   assign o_busy         = in_frame || (state_q == S_LEN_LO && acc && !i_rearm);
   assign o_load_done    = (state_q == S_DONE);
   assign o_load_err     = (state_q == S_ERR);
   assign o_err_code     = code_q;
   assign o_words_loaded = cnt_q;

endmodule
